digital_tube_decoder: RTL

Receive-side monitor for the 4-digit multiplexed 7-segment scan interface. It samples the active-low digit select and the segment bus, and decodes each segment pattern back to BCD. It checks the scan order (units→tens→hundreds→thousands), then commits a complete 4-digit frame with a valid pulse. It is used for display loop-back checking and for front-panel readback.

---
 rtl/digital_tube_decoder.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/digital_tube_decoder.sv
// Receive-side monitor for a 4-digit multiplexed 7-segment scan bus: decodes digits back to BCD,
// checks scan order and commits whole frames. Define DT_DEC_BLANK_EN to accept 0000000 as blank.
module digital_tube_decoder #(
  parameter int unsigned STABLE_CYC  = 1,
  parameter int unsigned TIMEOUT_CYC = 1023
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       en,
  input  logic [3:0] csn_in,
  input  logic [6:0] seg_in,
  output logic [3:0] single_digit,
  output logic [3:0] ten_digit,
  output logic [3:0] hundred_digit,
  output logic [3:0] kilo_digit,
  output logic       frame_valid,
  output logic       frame_err,
  output logic       seq_err,
  output logic       timeout
);

  localparam int unsigned SW = (STABLE_CYC < 2) ? 1 : $clog2(STABLE_CYC + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [SW-1:0] StableMax = SW'(STABLE_CYC);
  localparam logic [TW-1:0] TmoMax    = TW'(TIMEOUT_CYC);

  typedef enum logic [1:0] {StIdle, StGotU, StGotT, StGotH} state_e;

  // Returns {err, value}.
  function automatic logic [4:0] decode_seg(input logic [6:0] seg);
    case (seg)
      7'b1111110: decode_seg = 5'h00;
      7'b0110000: decode_seg = 5'h01;
      7'b1101101: decode_seg = 5'h02;
      7'b1111001: decode_seg = 5'h03;
      7'b0110011: decode_seg = 5'h04;
      7'b1011011: decode_seg = 5'h05;
      7'b1011111: decode_seg = 5'h06;
      7'b1110000: decode_seg = 5'h07;
      7'b1111111: decode_seg = 5'h08;
      7'b1111011: decode_seg = 5'h09;
`ifdef DT_DEC_BLANK_EN
      7'b0000000: decode_seg = 5'h0A;
`endif
      default:    decode_seg = 5'h1F;
    endcase
  endfunction

  state_e      state_q, state_d;
  logic [10:0] prev_q, prev_d;
  logic [SW-1:0] stab_q, stab_d;
  logic          captured_q, captured_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [3:0]  stage_u_q, stage_u_d, stage_t_q, stage_t_d, stage_h_q, stage_h_d;
  logic        err_u_q, err_u_d, err_t_q, err_t_d, err_h_q, err_h_d;
  logic [15:0] digits_q, digits_d;
  logic        frame_valid_q, frame_valid_d, frame_err_q, frame_err_d;
  logic        seq_err_q, seq_err_d, timeout_q, timeout_d;

  logic [10:0]   sample;
  logic [4:0]    dec;
  logic          legal, illegal, capture;
  logic [TW-1:0] tmo_inc;

  always_comb begin
    state_d       = state_q;
    prev_d        = prev_q;
    stab_d        = stab_q;
    captured_d    = captured_q;
    tmo_d         = tmo_q;
    stage_u_d     = stage_u_q;
    stage_t_d     = stage_t_q;
    stage_h_d     = stage_h_q;
    err_u_d       = err_u_q;
    err_t_d       = err_t_q;
    err_h_d       = err_h_q;
    digits_d      = digits_q;
    frame_err_d   = frame_err_q;
    frame_valid_d = 1'b0;
    seq_err_d     = 1'b0;
    timeout_d     = 1'b0;
    sample        = {csn_in, seg_in};
    dec           = decode_seg(seg_in);
    legal         = (csn_in == 4'b0111) || (csn_in == 4'b1011) ||
                    (csn_in == 4'b1101) || (csn_in == 4'b1110);
    illegal       = !legal && (csn_in != 4'b1111);
    capture       = 1'b0;
    tmo_inc       = tmo_q + 1'b1;

    if (en) begin
      prev_d = sample;
      if (csn_in != prev_q[10:7]) captured_d = 1'b0;
      if (illegal) begin
        // Illegal select wins over any timeout on the same sample.
        seq_err_d = 1'b1;
        state_d   = StIdle;
        stab_d    = '0;
        tmo_d     = '0;
      end else begin
        if (sample == prev_q) begin
          stab_d = (stab_q == StableMax) ? stab_q : stab_q + 1'b1;
        end else begin
          stab_d = SW'(1);
        end
        capture = legal && (stab_d == StableMax) && !captured_d;
        if (capture) begin
          captured_d = 1'b1;
          tmo_d      = '0;
          case (csn_in)
            4'b0111: begin
              stage_u_d = dec[3:0];
              err_u_d   = dec[4];
              state_d   = StGotU;
            end
            4'b1011: begin
              if (state_q == StGotU) begin
                stage_t_d = dec[3:0];
                err_t_d   = dec[4];
                state_d   = StGotT;
              end else begin
                seq_err_d = 1'b1;
                state_d   = StIdle;
              end
            end
            4'b1101: begin
              if (state_q == StGotT) begin
                stage_h_d = dec[3:0];
                err_h_d   = dec[4];
                state_d   = StGotH;
              end else begin
                seq_err_d = 1'b1;
                state_d   = StIdle;
              end
            end
            default: begin
              if (state_q == StGotH) begin
                digits_d      = {dec[3:0], stage_h_q, stage_t_q, stage_u_q};
                frame_err_d   = err_u_q | err_t_q | err_h_q | dec[4];
                frame_valid_d = 1'b1;
              end else begin
                seq_err_d = 1'b1;
              end
              state_d = StIdle;
            end
          endcase
        end else if (state_q != StIdle) begin
          if (tmo_inc == TmoMax) begin
            timeout_d = 1'b1;
            state_d   = StIdle;
            tmo_d     = '0;
          end else begin
            tmo_d = tmo_inc;
          end
        end else begin
          tmo_d = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= StIdle;
      prev_q        <= 11'h7FF;
      stab_q        <= '0;
      captured_q    <= 1'b0;
      tmo_q         <= '0;
      stage_u_q     <= '0;
      stage_t_q     <= '0;
      stage_h_q     <= '0;
      err_u_q       <= 1'b0;
      err_t_q       <= 1'b0;
      err_h_q       <= 1'b0;
      digits_q      <= '0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      seq_err_q     <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      prev_q        <= prev_d;
      stab_q        <= stab_d;
      captured_q    <= captured_d;
      tmo_q         <= tmo_d;
      stage_u_q     <= stage_u_d;
      stage_t_q     <= stage_t_d;
      stage_h_q     <= stage_h_d;
      err_u_q       <= err_u_d;
      err_t_q       <= err_t_d;
      err_h_q       <= err_h_d;
      digits_q      <= digits_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
      seq_err_q     <= seq_err_d;
      timeout_q     <= timeout_d;
    end
  end

  assign {kilo_digit, hundred_digit, ten_digit, single_digit} = digits_q;
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;
  assign seq_err     = seq_err_q;
  assign timeout     = timeout_q;

endmodule
